logic_unit_pipe: RTL and testbench

//   Parametrised, pipelined successor to the 2-input AND gate. Performs a

---
 rtl/logic_unit_pipe.sv | 90 +++++++++
 tb/tb_logic_unit_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NOR) with zero/all-ones flags,
// valid/ready handshake with bubble collapse, and a completed-result counter.
module logic_unit_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     in0,
  input  logic [W-1:0]     in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             zero,
  output logic             all_ones,
  output logic [CNT_W-1:0] count
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] zero_q;
  logic [STAGES-1:0] ones_q;
  logic [W-1:0]      dat [STAGES];
  logic [W-1:0]      res;

  always_comb begin
    res = '0;
    case (op)
      2'b00: res = in0 & in1;
      2'b01: res = in0 | in1;
      2'b10: res = in0 ^ in1;
      2'b11: res = ~(in0 | in1);
      default: res = '0;
    endcase
  end

  // A stage is blocked only when it and every stage after it hold data and
  // the consumer is stalled; written as a running AND to avoid a self-loop.
  always_comb begin
    logic chain;
    chain = 1'b1;
    load  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain   = chain & vld[i];
      load[i] = out_ready | ~chain;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      zero_q <= '0;
      ones_q <= '0;
      count  <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0]    <= res;
          zero_q[0] <= (res == '0);
          ones_q[0] <= &res;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i]    <= dat[i-1];
            zero_q[i] <= zero_q[i-1];
            ones_q[i] <= ones_q[i-1];
          end
        end
      end
      if (vld[STAGES-1] & out_ready) count <= count + 1'b1;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out       = dat[STAGES-1];
  assign zero      = zero_q[STAGES-1];
  assign all_ones  = ones_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: a 2-stage/4-bit-counter instance and a 3-stage instance,
// directed vectors with hand-computed results.
module tb_logic_unit_pipe;

  typedef struct {
    logic [31:0] exp;
    int          exp_cyc;
    bit          chk_lat;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  logic        iv2, ir2, ov2, or2, zero2, ones2;
  logic [1:0]  op2;
  logic [31:0] a2, b2, out2;
  logic [3:0]  count2;

  logic        iv3, ir3, ov3, or3, zero3, ones3;
  logic [1:0]  op3;
  logic [31:0] a3, b3, out3;
  logic [15:0] count3;

  ent_t q2[$];
  ent_t q3[$];
  ent_t e2, e3;
  int   ncmp = 0;
  int   nbad = 0;

  logic_unit_pipe #(.W(32), .STAGES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op(op2),
    .in0(a2), .in1(b2), .out_valid(ov2), .out_ready(or2), .out(out2),
    .zero(zero2), .all_ones(ones2), .count(count2)
  );

  logic_unit_pipe #(.W(32), .STAGES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .op(op3),
    .in0(a3), .in1(b3), .out_valid(ov3), .out_ready(or3), .out(out3),
    .zero(zero3), .all_ones(ones3), .count(count3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov2 === 1'b1 && or2 === 1'b1) begin
      if (q2.size() == 0) begin
        ncmp++; nbad++;
        $display("FAIL p2 unexpected result: got %h expected none", out2);
      end else begin
        e2 = q2.pop_front();
        cmp("p2 out", out2, e2.exp);
        cmp("p2 zero", {31'b0, zero2}, {31'b0, (e2.exp == 32'h0)});
        cmp("p2 all_ones", {31'b0, ones2}, {31'b0, (&e2.exp)});
        if (e2.chk_lat) cmp("p2 latency cycle", cyc, e2.exp_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ov3 === 1'b1 && or3 === 1'b1) begin
      if (q3.size() == 0) begin
        ncmp++; nbad++;
        $display("FAIL p3 unexpected result: got %h expected none", out3);
      end else begin
        e3 = q3.pop_front();
        cmp("p3 out", out3, e3.exp);
        cmp("p3 zero", {31'b0, zero3}, {31'b0, (e3.exp == 32'h0)});
        cmp("p3 all_ones", {31'b0, ones3}, {31'b0, (&e3.exp)});
      end
    end
  end

  task automatic send(input int sel, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input bit lat);
    bit   done = 1'b0;
    ent_t e;
    if (sel == 0) begin op2 = o; a2 = a; b2 = b; iv2 = 1'b1; end
    else          begin op3 = o; a3 = a; b3 = b; iv3 = 1'b1; end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (((sel == 0) ? ir2 : ir3) === 1'b1) begin
        e.exp     = exp;
        e.exp_cyc = cyc + ((sel == 0) ? 2 : 3);
        e.chk_lat = lat;
        if (sel == 0) q2.push_back(e); else q3.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      ncmp++; nbad++;
      $display("FAIL send timeout: got in_ready=0 for 50 cycles expected accept (pipe %0d)", sel);
    end
  endtask

  task automatic idle();
    iv2 = 1'b0;
    iv3 = 1'b0;
  endtask

  task automatic drain(input int sel);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (sel == 0) ok = (q2.size() == 0) && (ov2 === 1'b0);
      else          ok = (q3.size() == 0) && (ov3 === 1'b0);
      if (!ok) begin @(posedge clk); #1; end
    end
    ncmp++;
    if (!ok) begin
      nbad++;
      $display("FAIL drain timeout: got results pending expected empty (pipe %0d)", sel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1;
    iv2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0; or2 = 1'b1;
    iv3 = 1'b0; op3 = 2'b00; a3 = '0; b3 = '0; or3 = 1'b1;
    #12;
    cmp("reset out_valid", {31'b0, ov2}, 32'h0);
    cmp("reset in_ready", {31'b0, ir2}, 32'h1);
    cmp("reset count", {28'b0, count2}, 32'h0);
    cmp("reset out", out2, 32'h0);
    cmp("reset zero", {31'b0, zero2}, 32'h0);
    cmp("reset all_ones", {31'b0, ones2}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // reset mid-stream with two results in flight
    send(0, 2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b0);
    idle();
    drain(0);
    cmp("count before reset", {28'b0, count2}, 32'h1);
    or2 = 1'b0;
    send(0, 2'b01, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0);
    send(0, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0);
    idle();
    cmp("in flight out_valid", {31'b0, ov2}, 32'h1);
    #2 rst = 1'b1;
    #1;
    cmp("mid reset out_valid", {31'b0, ov2}, 32'h0);
    cmp("mid reset count", {28'b0, count2}, 32'h0);
    q2.delete();
    q3.delete();
    #3 rst = 1'b0;
    or2 = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin @(posedge clk); #1; end
    cmp("post reset count", {28'b0, count2}, 32'h0);

    // four ops back-to-back, latency checked
    send(0, 2'b00, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hF000_000F, 1'b1);
    send(0, 2'b01, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'hFFF0_0FFF, 1'b1);
    send(0, 2'b10, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h0FF0_0FF0, 1'b1);
    send(0, 2'b11, 32'hF0F0_00FF, 32'hFF00_0F0F, 32'h000F_F000, 1'b1);
    idle();
    drain(0);
    cmp("count after ops", {28'b0, count2}, 32'h4);

    // flags
    send(0, 2'b00, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
    send(0, 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    idle();
    drain(0);
    cmp("count after flags", {28'b0, count2}, 32'h6);

    // backpressure
    or2 = 1'b0;
    send(0, 2'b10, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0);
    send(0, 2'b01, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    op2 = 2'b00; a2 = 32'h8000_0001; b2 = 32'hFFFF_FFFF; iv2 = 1'b1;
    @(negedge clk);
    cmp("full in_ready", {31'b0, ir2}, 32'h0);
    cmp("stall out_valid", {31'b0, ov2}, 32'h1);
    cmp("stall out", out2, 32'hEDCB_A987);
    @(posedge clk); #1;
    @(negedge clk);
    cmp("still full in_ready", {31'b0, ir2}, 32'h0);
    cmp("stall out held", out2, 32'hEDCB_A987);
    @(posedge clk); #1;
    or2 = 1'b1;
    send(0, 2'b00, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    idle();
    drain(0);
    cmp("count after backpressure", {28'b0, count2}, 32'h9);

    // bubble collapse on the 3-stage pipe
    or3 = 1'b0;
    send(1, 2'b01, 32'h1111_0000, 32'h0000_2222, 32'h1111_2222, 1'b0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("p3 last stage valid", {31'b0, ov3}, 32'h1);
    @(posedge clk); #1;
    t0 = cyc;
    send(1, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    send(1, 2'b00, 32'h3C3C_3C3C, 32'h0FF0_0FF0, 32'h0C30_0C30, 1'b0);
    idle();
    cmp("p3 two accepts cycles", cyc - t0, 32'h2);
    @(negedge clk);
    cmp("p3 full in_ready", {31'b0, ir3}, 32'h0);
    @(posedge clk); #1;
    or3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("p3 back-to-back out_valid", {31'b0, ov3}, 32'h1);
    end
    @(posedge clk); #1;
    drain(1);
    cmp("p3 count", {16'b0, count3}, 32'h3);

    // counter wrap with a 4-bit counter
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++)
      send(0, 2'b00, 32'(i * 3), 32'hFFFF_FFFF, 32'(i * 3), 1'b0);
    idle();
    drain(0);
    cmp("count wrap", {28'b0, count2}, 32'h1);

    cmp("p2 queue empty", q2.size(), 32'h0);
    cmp("p3 queue empty", q3.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
